// File: rtl/count_seg7_display.sv
`default_nettype none
// ============================================================================
// Module      : count_seg7_display
// Description : 8-bit counter value to 3-digit BCD (double-dabble) with
//               multiplexed common-anode 7-segment scan and tc-stretched dp.
//               Optional macro: LEADING_ZERO_BLANK_EN (blank leading zeros).
// Revision    : 1.0 - initial release
// ============================================================================
module count_seg7_display #(
    parameter int REFRESH_DIV = 100000,
    parameter int TC_HOLD     = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] value,
    input  logic       tc,
    output logic       busy,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int c_ref_w = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int c_hold_w = $clog2(TC_HOLD + 1);
    localparam logic [c_ref_w-1:0]  c_ref_max   = c_ref_w'(REFRESH_DIV - 1);
    localparam logic [c_hold_w-1:0] c_hold_load = c_hold_w'(TC_HOLD);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_LATCH = 2'd2
    } state_t;

    state_t              r_state;
    logic [7:0]          r_shreg;
    logic [11:0]         r_bcd;
    logic [2:0]          r_iter;
    logic [7:0]          r_cap;
    logic [7:0]          r_last;
    logic                r_force;
    logic [3:0]          r_hund;
    logic [3:0]          r_tens;
    logic [3:0]          r_ones;
    logic [c_ref_w-1:0]  r_ref;
    logic [1:0]          r_idx;
    logic [c_hold_w-1:0] r_hold;

    logic [11:0] w_adj;
    logic [3:0]  w_digit;
    logic [3:0]  w_an_next;
    logic [6:0]  w_seg_next;
    logic        w_dp_next;

    function automatic logic [11:0] add3(input logic [11:0] b);
        logic [11:0] r;
        r = b;
        for (int i = 0; i < 3; i++) begin
            if (r[i*4 +: 4] >= 4'd5)
                r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    always_comb begin
        w_adj = add3(r_bcd);
    end

    // Conversion engine: a value change arriving mid-conversion is picked up
    // by the mismatch test on the first IDLE cycle after LATCH.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_shreg <= 8'd0;
            r_bcd   <= 12'd0;
            r_iter  <= 3'd0;
            r_cap   <= 8'd0;
            r_last  <= 8'd0;
            r_force <= 1'b1;
            r_hund  <= 4'd0;
            r_tens  <= 4'd0;
            r_ones  <= 4'd0;
            busy    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if ((value != r_last) || r_force) begin
                        r_shreg <= value;
                        r_cap   <= value;
                        r_bcd   <= 12'd0;
                        r_iter  <= 3'd0;
                        busy    <= 1'b1;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    {r_bcd, r_shreg} <= {w_adj, r_shreg} << 1;
                    r_iter <= r_iter + 3'd1;
                    if (r_iter == 3'd7)
                        r_state <= S_LATCH;
                end
                S_LATCH: begin
                    r_hund  <= r_bcd[11:8];
                    r_tens  <= r_bcd[7:4];
                    r_ones  <= r_bcd[3:0];
                    r_last  <= r_cap;
                    r_force <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_an_next = 4'b1111;
        w_digit   = 4'hF;
        case (r_idx)
            2'd0: begin w_an_next = 4'b1110; w_digit = r_ones; end
            2'd1: begin w_an_next = 4'b1101; w_digit = r_tens; end
            2'd2: begin w_an_next = 4'b1011; w_digit = r_hund; end
            default: begin w_an_next = 4'b1111; w_digit = 4'hF; end
        endcase
        w_seg_next = seg7(w_digit);
`ifdef LEADING_ZERO_BLANK_EN
        if ((r_idx == 2'd2) && (r_hund == 4'd0))
            w_seg_next = 7'h7F;
        if ((r_idx == 2'd1) && (r_hund == 4'd0) && (r_tens == 4'd0))
            w_seg_next = 7'h7F;
`endif
        w_dp_next = !((r_hold != '0) && (r_idx == 2'd0));
    end

    // an/seg/dp are all derived from the same r_idx in one register stage,
    // so a digit select and its segment pattern always change together.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ref  <= '0;
            r_idx  <= 2'd0;
            r_hold <= '0;
            an     <= 4'b1111;
            seg    <= 7'h7F;
            dp     <= 1'b1;
        end else begin
            if (r_ref == c_ref_max) begin
                r_ref <= '0;
                r_idx <= (r_idx == 2'd2) ? 2'd0 : r_idx + 2'd1;
            end else begin
                r_ref <= r_ref + 1'b1;
            end
            if (tc)
                r_hold <= c_hold_load;
            else if (r_hold != '0)
                r_hold <= r_hold - 1'b1;
            an  <= w_an_next;
            seg <= w_seg_next;
            dp  <= w_dp_next;
        end
    end

endmodule
`default_nettype wire
